// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one DataMemory port between the instruction-side
// (req0) and data-side (req1) cache controllers, with a per-access watchdog.
module mem_port_arbiter #(
    parameter int data_length    = 32,
    parameter int address_length = 10,
    parameter int line_width     = 128,
    parameter int timeout_cycles = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req0_read,
    input  logic                      req0_write,
    input  logic [address_length-1:0] req0_address,
    input  logic [data_length-1:0]    req0_wdata,
    output logic [line_width-1:0]     req0_rdata,
    output logic                      req0_ready,
    output logic                      req0_error,
    input  logic                      req1_read,
    input  logic                      req1_write,
    input  logic [address_length-1:0] req1_address,
    input  logic [data_length-1:0]    req1_wdata,
    output logic [line_width-1:0]     req1_rdata,
    output logic                      req1_ready,
    output logic                      req1_error,
    output logic                      mem_read_en,
    output logic                      mem_write_en,
    output logic [address_length-1:0] mem_address,
    output logic [data_length-1:0]    mem_wdata,
    input  logic [line_width-1:0]     mem_rdata,
    input  logic                      mem_ready,
    output logic [1:0]                grant,
    output logic                      busy
);
    localparam int CNT_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
    localparam bit WDOG_EN = (timeout_cycles != 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    logic [1:0]                      req_rd, req_wr, pend;
    logic [1:0][address_length-1:0]  req_addr;
    logic [1:0][data_length-1:0]     req_wd;

    assign req_rd   = {req1_read, req0_read};
    assign req_wr   = {req1_write, req0_write};
    assign req_addr = {req1_address, req0_address};
    assign req_wd   = {req1_wdata, req0_wdata};
    assign pend     = req_rd | req_wr;

    state_t                      state_q, state_d;
    logic                        last_q, last_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [address_length-1:0]   addr_q, addr_d;
    logic [data_length-1:0]      wdata_q, wdata_d;
    logic [1:0]                  grant_q, grant_d;
    logic [1:0][line_width-1:0]  rdata_q, rdata_d;
    logic [1:0]                  ready_q, ready_d, error_q, error_d;
    logic                        busy_q, busy_d;

    logic win, owner, timeout;

    assign owner   = grant_q[1];
    assign timeout = WDOG_EN && (cnt_q == CNT_LIM);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        ready_d = '0;
        error_d = '0;
        busy_d  = busy_q;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    // Contention goes to whoever did not win last time.
                    win     = (&pend) ? ~last_q : pend[1];
                    rd_en_d = req_rd[win];
                    wr_en_d = req_wr[win] & ~req_rd[win];
                    addr_d  = req_addr[win];
                    wdata_d = req_wd[win];
                    grant_d = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ready || timeout) begin
                    rd_en_d        = 1'b0;
                    wr_en_d        = 1'b0;
                    ready_d[owner] = 1'b1;
                    state_d        = RESPOND;
                    // A ready arriving on the timeout cycle still counts as success.
                    if (mem_ready) begin
                        if (rd_en_q) rdata_d[owner] = mem_rdata;
                    end else begin
                        error_d[owner] = 1'b1;
                    end
                end
            end
            RESPOND: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            grant_q <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            error_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign req0_rdata   = rdata_q[0];
    assign req1_rdata   = rdata_q[1];
    assign req0_ready   = ready_q[0];
    assign req1_ready   = ready_q[1];
    assign req0_error   = error_q[0];
    assign req1_error   = error_q[1];
    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign grant        = grant_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model.
module tb_mem_port_arbiter;
    localparam int DL = 32;
    localparam int AL = 10;
    localparam int LW = 128;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_read, req0_write, req1_read, req1_write;
    logic [AL-1:0] req0_address, req1_address;
    logic [DL-1:0] req0_wdata, req1_wdata;
    logic [LW-1:0] req0_rdata, req1_rdata;
    logic          req0_ready, req0_error, req1_ready, req1_error;
    logic          mem_read_en, mem_write_en;
    logic [AL-1:0] mem_address;
    logic [DL-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;
    logic [1:0]    grant;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for the randomized run
    bit            m_pend [2];
    bit            m_rd   [2];
    bit            m_wr   [2];
    logic [AL-1:0] m_ad   [2];
    logic [DL-1:0] m_wd   [2];
    logic [LW-1:0] m_exp  [2];
    int            m_last;

    mem_port_arbiter #(
        .data_length(DL), .address_length(AL), .line_width(LW), .timeout_cycles(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req0_read(req0_read), .req0_write(req0_write), .req0_address(req0_address),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_ready(req0_ready),
        .req0_error(req0_error),
        .req1_read(req1_read), .req1_write(req1_write), .req1_address(req1_address),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_ready(req1_ready),
        .req1_error(req1_error),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_read = 0; req0_write = 0; req0_address = '0; req0_wdata = '0;
        req1_read = 0; req1_write = 0; req1_address = '0; req1_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_reqs();
        req0_read  = m_pend[0] & m_rd[0];
        req0_write = m_pend[0] & m_wr[0];
        req0_address = m_ad[0]; req0_wdata = m_wd[0];
        req1_read  = m_pend[1] & m_rd[1];
        req1_write = m_pend[1] & m_wr[1];
        req1_address = m_ad[1]; req1_wdata = m_wd[1];
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({req0_rdata, req0_ready, req0_error, req1_rdata, req1_ready, req1_error,
             mem_read_en, mem_write_en, mem_address, mem_wdata, grant, busy} !== '0) begin
            $display("FAIL reset_outputs: got grant=%b busy=%b ren=%b wen=%b addr=%h r0=%h r1=%h, expected all 0",
                     grant, busy, mem_read_en, mem_write_en, mem_address, req0_rdata, req1_rdata);
            n_fail++;
        end
        // A stray mem_ready in IDLE must not do anything
        mem_ready = 1; mem_rdata = rand_line();
        tick();
        tick();
        mem_ready = 0;
        n_tests++;
        if ({busy, grant, req0_ready, req1_ready, req0_rdata, req1_rdata} !== '0) begin
            $display("FAIL idle_mem_ready: got busy=%b grant=%b rdy=%b%b, expected all 0",
                     busy, grant, req1_ready, req0_ready);
            n_fail++;
        end
    endtask

    task automatic test_single_read();
        logic [LW-1:0] line;
        int pulses;
        line = 128'hDEADBEEF_00000001_00000002_00000003;
        req0_read = 1; req0_address = 10'h040;
        tick();
        n_tests++;
        if ({grant, mem_read_en, mem_write_en, mem_address, busy} !== {2'b01, 1'b1, 1'b0, 10'h040, 1'b1}) begin
            $display("FAIL single_grant: got grant=%b ren=%b wen=%b addr=%h busy=%b, expected 01 1 0 040 1",
                     grant, mem_read_en, mem_write_en, mem_address, busy);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({grant, mem_read_en, req0_ready} !== {2'b01, 1'b1, 1'b0}) begin
                $display("FAIL single_hold: cycle %0d got grant=%b ren=%b rdy=%b, expected 01 1 0",
                         i, grant, mem_read_en, req0_ready);
                n_fail++;
            end
        end
        mem_ready = 1; mem_rdata = line;
        tick();
        n_tests++;
        if ({req0_ready, req0_error, req0_rdata, mem_read_en, req1_ready} !== {1'b1, 1'b0, line, 1'b0, 1'b0}) begin
            $display("FAIL single_respond: got rdy=%b err=%b rdata=%h ren=%b, expected 1 0 %h 0",
                     req0_ready, req0_error, req0_rdata, mem_read_en, line);
            n_fail++;
        end
        pulses = int'(req0_ready);
        req0_read = 0; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(req0_ready);
        end
        n_tests++;
        if (pulses != 1 || busy !== 1'b0 || grant !== 2'b00) begin
            $display("FAIL single_pulse: got pulses=%0d busy=%b grant=%b, expected 1 0 00", pulses, busy, grant);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req0_read = 1; req0_address = 10'h010;
        req1_write = 1; req1_address = 10'h020; req1_wdata = 32'hA5A5A5A5;
        tick();
        n_tests++;
        if ({grant, mem_read_en, mem_write_en, mem_address} !== {2'b01, 1'b1, 1'b0, 10'h010}) begin
            $display("FAIL simul_first: got grant=%b ren=%b wen=%b addr=%h, expected 01 1 0 010",
                     grant, mem_read_en, mem_write_en, mem_address);
            n_fail++;
        end
        mem_ready = 1; mem_rdata = rand_line();
        tick();
        req0_read = 0; mem_ready = 0;
        tick();
        n_tests++;
        if ({grant, busy} !== 3'b000) begin
            $display("FAIL simul_idle: got grant=%b busy=%b, expected 00 0", grant, busy);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({grant, mem_read_en, mem_write_en, mem_address, mem_wdata} !==
            {2'b10, 1'b0, 1'b1, 10'h020, 32'hA5A5A5A5}) begin
            $display("FAIL simul_second: got grant=%b ren=%b wen=%b addr=%h wdata=%h, expected 10 0 1 020 a5a5a5a5",
                     grant, mem_read_en, mem_write_en, mem_address, mem_wdata);
            n_fail++;
        end
        mem_ready = 1; mem_rdata = rand_line();
        tick();
        n_tests++;
        if ({req1_ready, req1_error, req0_ready, req1_rdata} !== {1'b1, 1'b0, 1'b0, {LW{1'b0}}}) begin
            $display("FAIL simul_write_resp: got rdy=%b err=%b rdy0=%b rdata=%h, expected 1 0 0 0",
                     req1_ready, req1_error, req0_ready, req1_rdata);
            n_fail++;
        end
        req1_write = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        do_reset();
        req0_read = 1; req1_read = 1;
        req0_address = 10'h111; req1_address = 10'h222;
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            n_tests++;
            if (grant !== exp_g) begin
                $display("FAIL fair_grant: txn %0d got grant=%b, expected %b", k, grant, exp_g);
                n_fail++;
            end
            mem_ready = 1; mem_rdata = rand_line();
            tick();
            n_tests++;
            if ({req1_ready, req0_ready} !== exp_g) begin
                $display("FAIL fair_ready: txn %0d got ready=%b%b, expected %b", k, req1_ready, req0_ready, exp_g);
                n_fail++;
            end
            if (exp_g == 2'b01) req0_read = 0; else req1_read = 0;
            mem_ready = 0;
            tick();
            req0_read = 1; req1_read = 1;
        end
        req0_read = 0; req1_read = 0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [LW-1:0] line;
        do_reset();
        req1_read = 1; req1_address = 10'h3F0;
        tick();
        n_tests++;
        if ({grant, mem_read_en} !== {2'b10, 1'b1}) begin
            $display("FAIL to_grant: got grant=%b ren=%b, expected 10 1", grant, mem_read_en);
            n_fail++;
        end
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            n_tests++;
            if ({mem_read_en, req1_ready, busy} !== 3'b101) begin
                $display("FAIL to_hold: cycle %0d got ren=%b rdy=%b busy=%b, expected 1 0 1",
                         i, mem_read_en, req1_ready, busy);
                n_fail++;
            end
        end
        tick();
        n_tests++;
        if ({mem_read_en, req1_ready, req1_error, req0_ready, req1_rdata} !==
            {1'b0, 1'b1, 1'b1, 1'b0, {LW{1'b0}}}) begin
            $display("FAIL to_abort: got ren=%b rdy=%b err=%b rdy0=%b rdata=%h, expected 0 1 1 0 0",
                     mem_read_en, req1_ready, req1_error, req0_ready, req1_rdata);
            n_fail++;
        end
        req1_read = 0;
        tick();
        n_tests++;
        if ({busy, grant, req1_ready, req1_error} !== 5'b0) begin
            $display("FAIL to_after: got busy=%b grant=%b rdy=%b err=%b, expected all 0",
                     busy, grant, req1_ready, req1_error);
            n_fail++;
        end
        // mem_ready on the very cycle the watchdog would fire: success wins
        line = rand_line();
        req0_read = 1; req0_address = 10'h055;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        mem_ready = 1; mem_rdata = line;
        tick();
        n_tests++;
        if ({req0_ready, req0_error, req0_rdata} !== {1'b1, 1'b0, line}) begin
            $display("FAIL to_tie: got rdy=%b err=%b rdata=%h, expected 1 0 %h",
                     req0_ready, req0_error, req0_rdata, line);
            n_fail++;
        end
        req0_read = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        req0_read = 1; req0_address = 10'h0AA;
        tick();
        tick();
        reset = 1;
        tick();
        n_tests++;
        if ({req0_rdata, req0_ready, req0_error, req1_rdata, req1_ready, req1_error,
             mem_read_en, mem_write_en, mem_address, mem_wdata, grant, busy} !== '0) begin
            $display("FAIL reset_mid: got grant=%b busy=%b ren=%b rdy=%b%b r0=%h, expected all 0",
                     grant, busy, mem_read_en, req1_ready, req0_ready, req0_rdata);
            n_fail++;
        end
        reset = 0;
        req0_read = 0;
        req1_read = 1; req1_address = 10'h1C3;
        tick();
        n_tests++;
        if ({grant, mem_read_en, mem_address, req0_ready} !== {2'b10, 1'b1, 10'h1C3, 1'b0}) begin
            $display("FAIL reset_mid_regrant: got grant=%b ren=%b addr=%h rdy0=%b, expected 10 1 1c3 0",
                     grant, mem_read_en, mem_address, req0_ready);
            n_fail++;
        end
        mem_ready = 1; mem_rdata = rand_line();
        tick();
        req1_read = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_rw_both();
        logic [LW-1:0] line;
        line = rand_line();
        req0_read = 1; req0_write = 1; req0_address = 10'h2B4; req0_wdata = $urandom;
        tick();
        n_tests++;
        if ({grant, mem_read_en, mem_write_en} !== {2'b01, 1'b1, 1'b0}) begin
            $display("FAIL rw_both: got grant=%b ren=%b wen=%b, expected 01 1 0", grant, mem_read_en, mem_write_en);
            n_fail++;
        end
        mem_ready = 1; mem_rdata = line;
        tick();
        n_tests++;
        if ({req0_ready, req0_rdata} !== {1'b1, line}) begin
            $display("FAIL rw_both_data: got rdy=%b rdata=%h, expected 1 %h", req0_ready, req0_rdata, line);
            n_fail++;
        end
        req0_read = 0; req0_write = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_random();
        int w, nh, r;
        bit to;
        logic [1:0] exp_g;
        logic [LW-1:0] line;
        do_reset();
        m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_ad[i] = '0; m_wd[i] = '0; m_exp[i] = '0;
        end
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_pend[i] && $urandom_range(0, 2) != 0) begin
                    m_pend[i] = 1;
                    m_rd[i] = 1'($urandom_range(0, 1));
                    m_wr[i] = m_rd[i] ? ($urandom_range(0, 3) == 0) : 1'b1;
                    m_ad[i] = AL'($urandom);
                    m_wd[i] = $urandom;
                end
            end
            if (!m_pend[0] && !m_pend[1]) begin
                r = $urandom_range(0, 1);
                m_pend[r] = 1; m_rd[r] = 1; m_wr[r] = 0; m_ad[r] = AL'($urandom);
            end
            drive_reqs();
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = rand_line();
            w = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
            exp_g = (w == 1) ? 2'b10 : 2'b01;
            tick();
            n_tests++;
            if ({grant, mem_read_en, mem_write_en, mem_address, mem_wdata, busy, req1_ready, req0_ready} !==
                {exp_g, m_rd[w], m_wr[w] & ~m_rd[w], m_ad[w], m_wd[w], 1'b1, 2'b00}) begin
                $display("FAIL rnd_grant: txn %0d got g=%b r=%b w=%b a=%h d=%h, expected g=%b r=%b w=%b a=%h d=%h",
                         t, grant, mem_read_en, mem_write_en, mem_address, mem_wdata,
                         exp_g, m_rd[w], m_wr[w] & ~m_rd[w], m_ad[w], m_wd[w]);
                n_fail++;
            end
            mem_ready = 0;
            if (w == 0) begin req0_address = AL'($urandom); req0_wdata = $urandom; end
            else        begin req1_address = AL'($urandom); req1_wdata = $urandom; end
            to = ($urandom_range(0, 5) == 0);
            nh = to ? TO - 1 : $urandom_range(0, TO - 1);
            for (int i = 0; i < nh; i++) begin
                tick();
                n_tests++;
                if ({grant, mem_read_en, mem_write_en, mem_address, req1_ready, req0_ready} !==
                    {exp_g, m_rd[w], m_wr[w] & ~m_rd[w], m_ad[w], 2'b00}) begin
                    $display("FAIL rnd_hold: txn %0d cycle %0d got g=%b r=%b w=%b a=%h, expected g=%b a=%h",
                             t, i, grant, mem_read_en, mem_write_en, mem_address, exp_g, m_ad[w]);
                    n_fail++;
                end
            end
            line = rand_line();
            if (!to) begin mem_ready = 1; mem_rdata = line; end
            tick();
            if (!to && m_rd[w]) m_exp[w] = line;
            n_tests++;
            if ({req1_ready, req0_ready, req1_error, req0_error, mem_read_en, mem_write_en, req1_rdata, req0_rdata} !==
                {exp_g, to ? exp_g : 2'b00, 2'b00, m_exp[1], m_exp[0]}) begin
                $display("FAIL rnd_resp: txn %0d got rdy=%b%b err=%b%b r1=%h r0=%h, expected rdy=%b to=%b r1=%h r0=%h",
                         t, req1_ready, req0_ready, req1_error, req0_error, req1_rdata, req0_rdata,
                         exp_g, to, m_exp[1], m_exp[0]);
                n_fail++;
            end
            m_pend[w] = 0;
            m_last = w;
            drive_reqs();
            mem_ready = 0;
            tick();
            n_tests++;
            if ({grant, busy, req1_ready, req0_ready, req1_error, req0_error} !== 7'b0) begin
                $display("FAIL rnd_idle: txn %0d got g=%b busy=%b rdy=%b%b err=%b%b, expected all 0",
                         t, grant, busy, req1_ready, req0_ready, req1_error, req0_error);
                n_fail++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
